alu_cmd_driver: RTL and testbench

ALU_CMD_DRIVER -- requirements
Module: alu_cmd_driver

---
 rtl/alu_cmd_driver.sv | 177 +++++++++++++++++
 tb/tb_alu_cmd_driver.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_driver.sv
// Command sequencer for a combinational ALU: registers one command, waits SETTLE cycles,
// samples the result into a response FIFO. Optional result checker under `ALU_CHECK_EN`.
module alu_cmd_driver #(
    parameter int SETTLE     = 2,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_a,
    input  logic [3:0] cmd_b,
    input  logic [2:0] cmd_op,
    output logic [7:0] alu_operands,
    output logic [2:0] alu_op,
    input  logic [7:0] alu_result,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [7:0] rsp_data,
    output logic [2:0] rsp_op,
    output logic       rsp_err,
    output logic       busy,
    output logic [1:0] fsm_state
);

    // Handshakes: a transfer happens on a posedge where valid and ready are both high;
    // ready never depends on valid, and a producer holds its payload until the transfer.

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
    localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [3:0]       WAIT_LOAD = 4'(SETTLE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_SAMPLE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       wait_cnt;
    logic             accept;
    logic             push;
    logic             pop;
    logic             fifo_full;

    logic [10:0]      fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   fifo_cnt;
    logic [10:0]      head;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (accept) state_nxt = ST_WAIT;
            ST_WAIT:   if (wait_cnt == 4'd0) state_nxt = ST_SAMPLE;
            ST_SAMPLE: if (push) state_nxt = ST_IDLE;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        cmd_ready = (state == ST_IDLE) && ena;
        busy      = (state != ST_IDLE);
        fsm_state = state;
        accept    = cmd_valid && cmd_ready;
        pop       = rsp_valid && rsp_ready;
        // A full FIFO still has room this cycle if the head leaves at the same edge.
        push      = (state == ST_SAMPLE) && (!fifo_full || pop);
    end

    // ---------------- settle counter ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wait_cnt <= 4'd0;
        end else if (accept) begin
            wait_cnt <= WAIT_LOAD;
        end else if ((state == ST_WAIT) && (wait_cnt != 4'd0)) begin
            wait_cnt <= wait_cnt - 4'd1;
        end
    end

    // ---------------- ALU operand registers ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_operands <= 8'h00;
            alu_op       <= 3'b000;
        end else if (accept) begin
            alu_operands <= {cmd_b, cmd_a};
            alu_op       <= cmd_op;
        end
    end

    // ---------------- response FIFO ----------------
    assign fifo_full = (fifo_cnt == CNT_FULL);
    assign rsp_valid = (fifo_cnt != '0);
    assign head      = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            fifo_mem[wr_ptr] <= {alu_op, alu_result};
        end
    end

    // Payload is forced to zero while empty so stale entries never show on the port.
    assign rsp_data = rsp_valid ? head[7:0]  : 8'h00;
    assign rsp_op   = rsp_valid ? head[10:8] : 3'b000;

`ifdef ALU_CHECK_EN
    logic [7:0] opnd_a;
    logic [7:0] opnd_b;
    logic [7:0] exp_result;
    logic       sample_err;
    logic       err_mem [FIFO_DEPTH];

    assign opnd_a = {4'b0000, alu_operands[3:0]};
    assign opnd_b = {4'b0000, alu_operands[7:4]};

    always_comb begin
        exp_result = 8'h00;
        case (alu_op)
            3'b000:  exp_result = opnd_a + opnd_b;
            3'b001:  exp_result = opnd_a - opnd_b;
            3'b010:  exp_result = opnd_a & opnd_b;
            3'b011:  exp_result = opnd_a | opnd_b;
            3'b100:  exp_result = opnd_a ^ opnd_b;
            3'b101:  exp_result = ~opnd_a;
            3'b110:  exp_result = opnd_a >> 1;
            default: exp_result = opnd_a << 1;
        endcase
    end

    assign sample_err = (alu_result != exp_result);

    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            err_mem[wr_ptr] <= sample_err;
        end
    end

    assign rsp_err = rsp_valid && err_mem[rd_ptr];
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Self-checking bench for alu_cmd_driver: ideal ALU with injectable corruption, queue-based
// response model, directed cases plus randomized traffic with random consumer backpressure.
module tb_alu_cmd_driver;

    localparam int SETTLE     = 2;
    localparam int FIFO_DEPTH = 4;

`ifdef ALU_CHECK_EN
    localparam bit CHECK_EN = 1'b1;
`else
    localparam bit CHECK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [3:0] cmd_a = 4'h0;
    logic [3:0] cmd_b = 4'h0;
    logic [2:0] cmd_op = 3'b000;
    logic [7:0] alu_operands;
    logic [2:0] alu_op;
    logic [7:0] alu_result;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_data;
    logic [2:0] rsp_op;
    logic       rsp_err;
    logic       busy;
    logic [1:0] fsm_state;

    logic [7:0] alu_mask = 8'h00;
    logic       rdy_req = 1'b0;
    logic       rand_rdy = 1'b0;
    logic       rnd_bit = 1'b0;

    int         n_tests = 0;
    int         n_fail = 0;
    logic [11:0] exp_q[$];

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    alu_cmd_driver #(.SETTLE(SETTLE), .FIFO_DEPTH(FIFO_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
        .alu_operands(alu_operands), .alu_op(alu_op), .alu_result(alu_result),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_op(rsp_op), .rsp_err(rsp_err),
        .busy(busy), .fsm_state(fsm_state)
    );

    // Ideal ALU arithmetic on plain integers, reduced mod 256.
    function automatic logic [7:0] ref_alu(input int a, input int b, input int op);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a & b;
            3:       r = a | b;
            4:       r = a ^ b;
            5:       r = 255 - a;
            6:       r = a / 2;
            default: r = a * 2;
        endcase
        return 8'(((r % 256) + 256) % 256);
    endfunction

    assign alu_result = ref_alu(int'(alu_operands[3:0]), int'(alu_operands[7:4]), int'(alu_op)) ^ alu_mask;
    assign rsp_ready  = rdy_req | (rand_rdy & rnd_bit);

    always begin
        @(posedge clk);
        #1;
        rnd_bit = 1'($urandom_range(0, 1));
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_n && rsp_valid && rsp_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_rsp", 32'({rsp_err, rsp_op, rsp_data}), 32'hFFFF);
            end else begin
                check_eq("rsp_entry", 32'({rsp_err, rsp_op, rsp_data}), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                            input logic [7:0] mask);
        bit         done = 1'b0;
        logic [7:0] data;
        logic       err;
        cmd_a = a;
        cmd_b = b;
        cmd_op = op;
        cmd_valid = 1'b1;
        for (int i = 0; i < 400 && !done; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                alu_mask = mask;
                @(posedge clk);
                done = 1'b1;
            end
        end
        if (done) begin
            data = ref_alu(int'(a), int'(b), int'(op)) ^ mask;
            err  = CHECK_EN && (mask != 8'h00);
            exp_q.push_back({err, op, data});
            #1;
        end else begin
            check_eq("accept_timeout", 32'd0, 32'd1);
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp();
        bit seen = 1'b0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(posedge clk);
            #1;
            seen = rsp_valid;
        end
        if (!seen) check_eq("rsp_timeout", 32'd0, 32'd1);
    endtask

    task automatic pop_one();
        rdy_req = 1'b1;
        @(posedge clk);
        #1;
        rdy_req = 1'b0;
    endtask

    task automatic drain();
        rdy_req = 1'b1;
        for (int i = 0; i < 2000 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        check_eq("drain_left", 32'(exp_q.size()), 32'd0);
        @(posedge clk);
        #1;
        check_eq("drain_empty", 32'(rsp_valid), 32'd0);
        rdy_req = 1'b0;
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int n;
        ena = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_rsp_data", 32'(rsp_data), 32'd0);
        check_eq("rst_rsp_op", 32'(rsp_op), 32'd0);
        check_eq("rst_rsp_err", 32'(rsp_err), 32'd0);
        check_eq("rst_operands", 32'(alu_operands), 32'd0);
        check_eq("rst_alu_op", 32'(alu_op), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);

        // basic add with response latency
        send_cmd(4'd3, 4'd5, 3'b000, 8'h00);
        check_eq("add_operands", 32'(alu_operands), 32'h53);
        check_eq("add_busy", 32'(busy), 32'd1);
        n = 0;
        for (int i = 1; i <= 30 && n == 0; i++) begin
            @(posedge clk);
            #1;
            if (rsp_valid) n = i;
        end
        check_eq("add_latency", 32'(n), 32'(SETTLE + 1));
        check_eq("add_data", 32'(rsp_data), 32'h08);
        check_eq("add_op", 32'(rsp_op), 32'd0);
        check_eq("add_err", 32'(rsp_err), 32'd0);
        pop_one();

        // subtract wrap and complement
        send_cmd(4'd3, 4'd5, 3'b001, 8'h00);
        wait_rsp();
        check_eq("sub_data", 32'(rsp_data), 32'hFE);
        check_eq("sub_err", 32'(rsp_err), 32'd0);
        pop_one();
        send_cmd(4'd5, 4'd0, 3'b101, 8'h00);
        wait_rsp();
        check_eq("not_data", 32'(rsp_data), 32'hFA);
        check_eq("not_err", 32'(rsp_err), 32'd0);
        pop_one();

        // ena gating
        @(posedge clk);
        #1;
        ena = 1'b0;
        cmd_a = 4'd7;
        cmd_b = 4'd2;
        cmd_op = 3'b100;
        cmd_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_eq("ena_block", 32'(cmd_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        check_eq("ena_no_accept", 32'(busy), 32'd0);
        ena = 1'b1;
        @(negedge clk);
        check_eq("ena_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        check_eq("ena_accept", 32'(busy), 32'd1);
        exp_q.push_back({1'b0, 3'b100, ref_alu(7, 2, 4)});
        cmd_valid = 1'b0;
        drain();

        // backpressure: one more command than the FIFO holds
        for (int i = 0; i <= FIFO_DEPTH; i++) begin
            send_cmd(4'(i + 1), 4'(2 * i), 3'(i), 8'h00);
        end
        repeat (SETTLE + 2) @(posedge clk);
        #1;
        check_eq("bp_busy", 32'(busy), 32'd1);
        check_eq("bp_ready", 32'(cmd_ready), 32'd0);
        check_eq("bp_head", 32'(rsp_data), 32'(ref_alu(1, 0, 0)));
        pop_one();
        check_eq("bp_pushed", 32'(busy), 32'd0);
        check_eq("bp_ready_back", 32'(cmd_ready), 32'd1);
        drain();

        // corrupted ALU result
        send_cmd(4'd1, 4'd1, 3'b000, 8'h02);
        wait_rsp();
        check_eq("err_data", 32'(rsp_data), 32'h00);
        check_eq("err_flag", 32'(rsp_err), 32'(CHECK_EN));
        pop_one();
        alu_mask = 8'h00;

        // randomized traffic with random consumer stalls
        rand_rdy = 1'b1;
        for (int i = 0; i < 40; i++) begin
            logic [7:0] m;
            m = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
            send_cmd(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                     3'($urandom_range(0, 7)), m);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end
        rand_rdy = 1'b0;
        alu_mask = 8'h00;
        drain();

        // reset during WAIT with two entries queued
        send_cmd(4'd2, 4'd3, 3'b010, 8'h00);
        send_cmd(4'd4, 4'd6, 3'b011, 8'h00);
        send_cmd(4'd9, 4'd1, 3'b000, 8'h00);
        check_eq("mid_in_wait", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        exp_q.delete();
        check_eq("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid_busy", 32'(busy), 32'd0);
        check_eq("mid_operands", 32'(alu_operands), 32'd0);
        check_eq("mid_rsp_data", 32'(rsp_data), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("mid_ready", 32'(cmd_ready), 32'd1);
        check_eq("mid_still_empty", 32'(rsp_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
